// File: rtl/ob_pkg.sv
// Order-book control types shared by the limit-match execution stage and its neighbours.
// Carries the decision payload, the trade response and the execution FSM state encoding.
package ob_pkg;

    localparam int QTY_W   = 16;
    localparam int PRICE_W = 16;
    localparam int UID_W   = 16;

    typedef logic [QTY_W-1:0]   quantity_t;
    typedef logic [PRICE_W-1:0] price_t;
    typedef logic [UID_W-1:0]   uid_t;

    // Fields of a matched trade that survive into execution.
    typedef struct packed {
        logic      bid_consumed;
        logic      ask_consumed;
        uid_t      bid_uid;
        uid_t      ask_uid;
        price_t    ask_price;
        quantity_t quantity;
        quantity_t bid_rem_qty;
        quantity_t ask_rem_qty;
    } lm_trade_t;

    typedef struct packed {
        logic      lm_ask_lm_bid;
        lm_trade_t trade;
    } cntrl_mk_t;

    typedef struct packed {
        uid_t      bid_uid;
        uid_t      ask_uid;
        price_t    price;
        quantity_t quantity;
    } trade_rsp_t;

    typedef enum logic [2:0] {
        IDLE,
        QRY,
        WAIT,
        UPDATE,
        EMIT,
        SETTLE
    } lm_exec_state_t;

    // Limit trades always execute at the resting ask price.
    function automatic trade_rsp_t lm_trade_to_rsp(input lm_trade_t t);
        trade_rsp_t r;
        r.bid_uid  = t.bid_uid;
        r.ask_uid  = t.ask_uid;
        r.price    = t.ask_price;
        r.quantity = t.quantity;
        return r;
    endfunction

endpackage

// File: rtl/ob_cntrl_lm_exec.sv
// Limit<->limit trade executor: query decision, retire/trim book heads, emit one response.
// Latency: trade_qry -> rsp_vld 3 cycles minimum; table ops held until rdy, rsp held until accept.
// Optional statistics counters behind OB_CNTRL_LM_EXEC_STATS_EN.
module ob_cntrl_lm_exec
    import ob_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
`ifdef OB_CNTRL_LM_EXEC_STATS_EN
    ,
    parameter int STAT_W = 32
`endif
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       trade_qry,
    input  logic       trade_vld_r,
    input  cntrl_mk_t  trade_r,
    output logic       lm_bid_pop,
    output logic       lm_bid_upt,
    output quantity_t  lm_bid_upt_qty,
    input  logic       lm_bid_rdy,
    output logic       lm_ask_pop,
    output logic       lm_ask_upt,
    output quantity_t  lm_ask_upt_qty,
    input  logic       lm_ask_rdy,
    output logic       rsp_vld,
    output trade_rsp_t rsp,
    input  logic       rsp_accept,
`ifdef OB_CNTRL_LM_EXEC_STATS_EN
    output logic [STAT_W-1:0] stat_trades_r,
    output logic [STAT_W-1:0] stat_shares_r,
`endif
    output logic       busy
);

    // A zero-length settle still spends one cycle in SETTLE.
    localparam int SETTLE_LAST = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
    localparam int CNT_W       = (SETTLE_LAST > 0) ? $clog2(SETTLE_LAST + 1) : 1;

    lm_exec_state_t   state_q, state_d;
    lm_trade_t        trade_q, trade_d;
    logic             bid_done_q, bid_done_d;
    logic             ask_done_q, ask_done_d;
    logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;

    logic bid_op;
    logic ask_op;

    assign bid_op = (state_q == UPDATE) && !bid_done_q;
    assign ask_op = (state_q == UPDATE) && !ask_done_q;

    assign lm_bid_pop     = bid_op && trade_q.bid_consumed;
    assign lm_bid_upt     = bid_op && !trade_q.bid_consumed;
    assign lm_bid_upt_qty = lm_bid_upt ? trade_q.bid_rem_qty : '0;
    assign lm_ask_pop     = ask_op && trade_q.ask_consumed;
    assign lm_ask_upt     = ask_op && !trade_q.ask_consumed;
    assign lm_ask_upt_qty = lm_ask_upt ? trade_q.ask_rem_qty : '0;

    assign trade_qry = (state_q == QRY);
    assign busy      = (state_q != IDLE);
    assign rsp_vld   = (state_q == EMIT);
    assign rsp       = rsp_vld ? lm_trade_to_rsp(trade_q) : '0;

    always_comb begin
        state_d      = state_q;
        trade_d      = trade_q;
        bid_done_d   = bid_done_q;
        ask_done_d   = ask_done_q;
        settle_cnt_d = settle_cnt_q;
        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = QRY;
                end
            end
            QRY: begin
                state_d = WAIT;
            end
            WAIT: begin
                // A zero-quantity decision is dropped rather than touching the book.
                if (trade_vld_r && trade_r.lm_ask_lm_bid && (trade_r.trade.quantity != '0)) begin
                    trade_d    = trade_r.trade;
                    bid_done_d = 1'b0;
                    ask_done_d = 1'b0;
                    state_d    = UPDATE;
                end else begin
                    state_d = IDLE;
                end
            end
            UPDATE: begin
                bid_done_d = bid_done_q || lm_bid_rdy;
                ask_done_d = ask_done_q || lm_ask_rdy;
                if (bid_done_d && ask_done_d) begin
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (rsp_accept) begin
                    settle_cnt_d = '0;
                    state_d      = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt_q == CNT_W'(SETTLE_LAST)) begin
                    state_d = IDLE;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            trade_q      <= '0;
            bid_done_q   <= 1'b0;
            ask_done_q   <= 1'b0;
            settle_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            trade_q      <= trade_d;
            bid_done_q   <= bid_done_d;
            ask_done_q   <= ask_done_d;
            settle_cnt_q <= settle_cnt_d;
        end
    end

`ifdef OB_CNTRL_LM_EXEC_STATS_EN
    logic [STAT_W-1:0] stat_trades_q;
    logic [STAT_W-1:0] stat_shares_q;
    logic [STAT_W:0]   shares_sum;
    logic              rsp_hs;

    assign rsp_hs     = rsp_vld && rsp_accept;
    assign shares_sum = {1'b0, stat_shares_q} + (STAT_W + 1)'(trade_q.quantity);

    // Both counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_trades_q <= '0;
            stat_shares_q <= '0;
        end else if (rsp_hs) begin
            if (stat_trades_q != '1) begin
                stat_trades_q <= stat_trades_q + 1'b1;
            end
            stat_shares_q <= shares_sum[STAT_W] ? '1 : shares_sum[STAT_W-1:0];
        end
    end

    assign stat_trades_r = stat_trades_q;
    assign stat_shares_r = stat_shares_q;
`endif

endmodule

// File: tb/tb_ob_cntrl_lm_exec.sv
// Bench for ob_cntrl_lm_exec: decision-stage responder, table/egress monitor and rsp scoreboard.
module tb_ob_cntrl_lm_exec;
    import ob_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       trade_qry;
    logic       trade_vld_r;
    cntrl_mk_t  trade_r;
    logic       lm_bid_pop, lm_bid_upt, lm_bid_rdy;
    quantity_t  lm_bid_upt_qty;
    logic       lm_ask_pop, lm_ask_upt, lm_ask_rdy;
    quantity_t  lm_ask_upt_qty;
    logic       rsp_vld;
    trade_rsp_t rsp;
    logic       rsp_accept;
    logic       busy;
`ifdef OB_CNTRL_LM_EXEC_STATS_EN
    logic [31:0] stat_trades_r;
    logic [31:0] stat_shares_r;
`endif

    always #5 clk = ~clk;

    ob_cntrl_lm_exec #(.SETTLE_CYCLES(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .trade_qry      (trade_qry),
        .trade_vld_r    (trade_vld_r),
        .trade_r        (trade_r),
        .lm_bid_pop     (lm_bid_pop),
        .lm_bid_upt     (lm_bid_upt),
        .lm_bid_upt_qty (lm_bid_upt_qty),
        .lm_bid_rdy     (lm_bid_rdy),
        .lm_ask_pop     (lm_ask_pop),
        .lm_ask_upt     (lm_ask_upt),
        .lm_ask_upt_qty (lm_ask_upt_qty),
        .lm_ask_rdy     (lm_ask_rdy),
        .rsp_vld        (rsp_vld),
        .rsp            (rsp),
        .rsp_accept     (rsp_accept),
`ifdef OB_CNTRL_LM_EXEC_STATS_EN
        .stat_trades_r  (stat_trades_r),
        .stat_shares_r  (stat_shares_r),
`endif
        .busy           (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    trade_rsp_t exp_q[$];

    logic      dec_vld;
    cntrl_mk_t dec_trade;

    int bid_op_cyc = 0, ask_op_cyc = 0;
    int bid_pop_hs = 0, bid_upt_hs = 0, ask_pop_hs = 0, ask_upt_hs = 0;
    int pair_pop = 0, conflict = 0, qry_cnt = 0, rsp_hs = 0;
    quantity_t last_bid_qty = '0, last_ask_qty = '0;

    // Decision-stage model: match the two heads at the given prices/quantities.
    function automatic cntrl_mk_t mk_trade(input logic [15:0] b_uid, input logic [15:0] b_px,
                                           input logic [15:0] b_qty, input logic [15:0] a_uid,
                                           input logic [15:0] a_px, input logic [15:0] a_qty);
        cntrl_mk_t m;
        quantity_t q;
        q = (b_qty < a_qty) ? b_qty : a_qty;
        m.lm_ask_lm_bid      = (b_px >= a_px);
        m.trade.bid_consumed = (b_qty == q);
        m.trade.ask_consumed = (a_qty == q);
        m.trade.bid_uid      = b_uid;
        m.trade.ask_uid      = a_uid;
        m.trade.ask_price    = a_px;
        m.trade.quantity     = q;
        m.trade.bid_rem_qty  = b_qty - q;
        m.trade.ask_rem_qty  = a_qty - q;
        return m;
    endfunction

    // Decision arrives the cycle after the query pulse.
    initial begin
        trade_vld_r = 1'b0;
        trade_r     = '0;
        forever begin
            @(negedge clk);
            if (trade_qry === 1'b1) begin
                @(posedge clk);
                #1;
                trade_vld_r = dec_vld;
                trade_r     = dec_trade;
                @(posedge clk);
                #1;
                trade_vld_r = 1'b0;
                trade_r     = '0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (lm_bid_pop || lm_bid_upt) bid_op_cyc++;
            if (lm_ask_pop || lm_ask_upt) ask_op_cyc++;
            if (lm_bid_pop && lm_bid_rdy) bid_pop_hs++;
            if (lm_ask_pop && lm_ask_rdy) ask_pop_hs++;
            if (lm_bid_upt && lm_bid_rdy) begin
                bid_upt_hs++;
                last_bid_qty = lm_bid_upt_qty;
            end
            if (lm_ask_upt && lm_ask_rdy) begin
                ask_upt_hs++;
                last_ask_qty = lm_ask_upt_qty;
            end
            if (lm_bid_pop && lm_ask_pop && lm_bid_rdy && lm_ask_rdy) pair_pop++;
            if ((lm_bid_pop && lm_bid_upt) || (lm_ask_pop && lm_ask_upt)) conflict++;
            if (trade_qry) qry_cnt++;
            if (rsp_vld && rsp_accept) rsp_hs++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic wait_qry(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (trade_qry === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_rsp(output bit ok, output int cyc);
        ok  = 1'b0;
        cyc = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            cyc++;
            if (rsp_vld === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        n_checks++;
        if (trade_qry !== 1'b0) begin
            n_fail++; $display("FAIL reset_qry: got %b want 0", trade_qry);
        end
        n_checks++;
        if ({lm_bid_pop, lm_bid_upt, lm_ask_pop, lm_ask_upt} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_table_ops: got %b want 0000",
                               {lm_bid_pop, lm_bid_upt, lm_ask_pop, lm_ask_upt});
        end
        n_checks++;
        if ({lm_bid_upt_qty, lm_ask_upt_qty} !== 32'h0) begin
            n_fail++; $display("FAIL reset_upt_qty: got %h want 0", {lm_bid_upt_qty, lm_ask_upt_qty});
        end
        n_checks++;
        if (rsp_vld !== 1'b0 || rsp !== '0) begin
            n_fail++; $display("FAIL reset_rsp: got vld=%b rsp=%h want 0/0", rsp_vld, rsp);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // T1: partial fill of the bid.
    task automatic test_partial_fill();
        int bp0 = bid_pop_hs, bu0 = bid_upt_hs, ap0 = ask_pop_hs, au0 = ask_upt_hs, cf0 = conflict;
        bit ok;
        int cyc;
        trade_rsp_t exp_r;
        logic [31:0] ops;
        dec_vld   = 1'b1;
        dec_trade = mk_trade(16'h0011, 16'd100, 16'd10, 16'h0022, 16'd98, 16'd4);
        exp_q.push_back('{bid_uid: 16'h0011, ask_uid: 16'h0022, price: 16'd98, quantity: 16'd4});
        en = 1'b1;
        wait_qry(ok);
        en = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL t1_qry: no trade_qry within 20 cycles");
        end
        wait_rsp(ok, cyc);
        n_checks++;
        if (!ok || cyc != 3) begin
            n_fail++; $display("FAIL t1_latency: rsp_vld seen=%b after %0d cycles want 3", ok, cyc);
        end
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL t1_rsp: scoreboard empty");
        end else begin
            exp_r = exp_q.pop_front();
            if (rsp !== exp_r) begin
                n_fail++; $display("FAIL t1_rsp: got %h want %h", rsp, exp_r);
            end
        end
        wait_idle(ok);
        @(negedge clk);
        ops = {8'(bid_pop_hs - bp0), 8'(bid_upt_hs - bu0), 8'(ask_pop_hs - ap0), 8'(ask_upt_hs - au0)};
        n_checks++;
        if (ops !== 32'h00010100) begin
            n_fail++; $display("FAIL t1_ops: got bpop/bupt/apop/aupt=%h want 00010100", ops);
        end
        n_checks++;
        if (last_bid_qty !== 16'd6) begin
            n_fail++; $display("FAIL t1_bid_upt_qty: got %0d want 6", last_bid_qty);
        end
        n_checks++;
        if (conflict != cf0) begin
            n_fail++; $display("FAIL t1_pop_upt_conflict: got %0d want 0", conflict - cf0);
        end
    endtask

    // T2: equal quantities retire both heads together, then settle for 2 cycles.
    task automatic test_equal_fill();
        int pp0 = pair_pop, bu0 = bid_upt_hs, au0 = ask_upt_hs, q0 = qry_cnt;
        bit ok;
        int cyc;
        int settle;
        trade_rsp_t exp_r;
        dec_vld   = 1'b1;
        dec_trade = mk_trade(16'h0031, 16'd50, 16'd5, 16'h0042, 16'd50, 16'd5);
        exp_q.push_back('{bid_uid: 16'h0031, ask_uid: 16'h0042, price: 16'd50, quantity: 16'd5});
        en = 1'b1;
        wait_qry(ok);
        en = 1'b0;
        wait_rsp(ok, cyc);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL t2_rsp_timeout: no rsp_vld within 30 cycles");
        end
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL t2_rsp: scoreboard empty");
        end else begin
            exp_r = exp_q.pop_front();
            if (rsp !== exp_r) begin
                n_fail++; $display("FAIL t2_rsp: got %h want %h", rsp, exp_r);
            end
        end
        settle = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy) settle++;
            else break;
        end
        n_checks++;
        if (settle != 2) begin
            n_fail++; $display("FAIL t2_settle: busy %0d cycles after accept want 2", settle);
        end
        @(negedge clk);
        n_checks++;
        if (pair_pop - pp0 != 1 || bid_upt_hs != bu0 || ask_upt_hs != au0) begin
            n_fail++; $display("FAIL t2_both_pop: got pair=%0d bupt=%0d aupt=%0d want 1/0/0",
                               pair_pop - pp0, bid_upt_hs - bu0, ask_upt_hs - au0);
        end
        n_checks++;
        if (qry_cnt - q0 != 1) begin
            n_fail++; $display("FAIL t2_no_requery: got %0d queries want 1", qry_cnt - q0);
        end
    endtask

    // T3: no decision -> straight back to IDLE, and a held en re-queries.
    task automatic test_no_decision();
        int hs0 = bid_pop_hs + bid_upt_hs + ask_pop_hs + ask_upt_hs, r0 = rsp_hs;
        bit ok;
        dec_vld   = 1'b0;
        dec_trade = mk_trade(16'h0001, 16'd10, 16'd1, 16'h0002, 16'd10, 16'd1);
        en = 1'b1;
        wait_qry(ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL t3_qry: no trade_qry within 20 cycles");
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || trade_qry !== 1'b0) begin
            n_fail++; $display("FAIL t3_wait: got busy=%b qry=%b want 1/0", busy, trade_qry);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL t3_idle_next: got busy=%b want 0", busy);
        end
        @(negedge clk);
        n_checks++;
        if (trade_qry !== 1'b1) begin
            n_fail++; $display("FAIL t3_requery: got trade_qry=%b want 1", trade_qry);
        end
        en = 1'b0;
        wait_idle(ok);
        repeat (3) @(negedge clk);
        n_checks++;
        if ((bid_pop_hs + bid_upt_hs + ask_pop_hs + ask_upt_hs) != hs0 || rsp_hs != r0) begin
            n_fail++; $display("FAIL t3_no_ops: got ops=%0d rsp=%0d want 0/0",
                               bid_pop_hs + bid_upt_hs + ask_pop_hs + ask_upt_hs - hs0, rsp_hs - r0);
        end
    endtask

    // T4: bid table stalls 3 cycles while ask completes at once.
    task automatic test_bid_stall();
        int bc0 = bid_op_cyc, ac0 = ask_op_cyc, bu0 = bid_upt_hs, ap0 = ask_pop_hs;
        bit ok;
        bit seen;
        trade_rsp_t exp_r;
        lm_bid_rdy = 1'b0;
        dec_vld    = 1'b1;
        dec_trade  = mk_trade(16'h0051, 16'd70, 16'd8, 16'h0062, 16'd69, 16'd3);
        exp_q.push_back('{bid_uid: 16'h0051, ask_uid: 16'h0062, price: 16'd69, quantity: 16'd3});
        en = 1'b1;
        wait_qry(ok);
        en = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (lm_bid_upt === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL t4_update: lm_bid_upt never asserted");
        end
        repeat (3) @(negedge clk);
        lm_bid_rdy = 1'b1;
        @(negedge clk);
        n_checks++;
        if (rsp_vld !== 1'b1) begin
            n_fail++; $display("FAIL t4_emit: got rsp_vld=%b want 1 after bid rdy", rsp_vld);
        end
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL t4_rsp: scoreboard empty");
        end else begin
            exp_r = exp_q.pop_front();
            if (rsp !== exp_r) begin
                n_fail++; $display("FAIL t4_rsp: got %h want %h", rsp, exp_r);
            end
        end
        wait_idle(ok);
        @(negedge clk);
        n_checks++;
        if (bid_op_cyc - bc0 != 4 || ask_op_cyc - ac0 != 1) begin
            n_fail++; $display("FAIL t4_op_cycles: got bid=%0d ask=%0d want 4/1",
                               bid_op_cyc - bc0, ask_op_cyc - ac0);
        end
        n_checks++;
        if (bid_upt_hs - bu0 != 1 || ask_pop_hs - ap0 != 1 || last_bid_qty !== 16'd5) begin
            n_fail++; $display("FAIL t4_ops: got bupt=%0d apop=%0d qty=%0d want 1/1/5",
                               bid_upt_hs - bu0, ask_pop_hs - ap0, last_bid_qty);
        end
    endtask

    // T5a: egress backpressure holds rsp stable.
    task automatic test_accept_stall();
        bit ok;
        int cyc;
        int held;
        trade_rsp_t first;
        trade_rsp_t exp_r;
        rsp_accept = 1'b0;
        dec_vld    = 1'b1;
        dec_trade  = mk_trade(16'h0071, 16'd61, 16'd7, 16'h0082, 16'd60, 16'd9);
        exp_q.push_back('{bid_uid: 16'h0071, ask_uid: 16'h0082, price: 16'd60, quantity: 16'd7});
        en = 1'b1;
        wait_qry(ok);
        en = 1'b0;
        wait_rsp(ok, cyc);
        first = rsp;
        held  = ok ? 1 : 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rsp_vld === 1'b1 && rsp === first) held++;
        end
        rsp_accept = 1'b1;
        @(negedge clk);
        n_checks++;
        if (held != 6) begin
            n_fail++; $display("FAIL t5_hold: rsp stable for %0d cycles want 6", held);
        end
        n_checks++;
        if (rsp_vld !== 1'b0) begin
            n_fail++; $display("FAIL t5_drop: got rsp_vld=%b want 0 after accept", rsp_vld);
        end
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL t5_rsp: scoreboard empty");
        end else begin
            exp_r = exp_q.pop_front();
            if (first !== exp_r) begin
                n_fail++; $display("FAIL t5_rsp: got %h want %h", first, exp_r);
            end
        end
        wait_idle(ok);
        n_checks++;
        if (last_ask_qty !== 16'd2) begin
            n_fail++; $display("FAIL t5_ask_upt_qty: got %0d want 2", last_ask_qty);
        end
    endtask

    // T5b: reset during UPDATE discards the captured trade.
    task automatic test_reset_in_update();
        int hs0, r0, q0;
        bit ok;
        bit seen;
        lm_bid_rdy = 1'b0;
        lm_ask_rdy = 1'b0;
        dec_vld    = 1'b1;
        dec_trade  = mk_trade(16'h0091, 16'd80, 16'd3, 16'h00a2, 16'd80, 16'd3);
        en = 1'b1;
        wait_qry(ok);
        en = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (lm_bid_pop === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL t5r_update: lm_bid_pop never asserted");
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({trade_qry, lm_bid_pop, lm_bid_upt, lm_ask_pop, lm_ask_upt, rsp_vld, busy} !== 7'b0 ||
            rsp !== '0 || lm_bid_upt_qty !== '0 || lm_ask_upt_qty !== '0) begin
            n_fail++; $display("FAIL t5r_async_clear: got ctl=%b rsp=%h want all 0",
                               {trade_qry, lm_bid_pop, lm_bid_upt, lm_ask_pop, lm_ask_upt, rsp_vld, busy}, rsp);
        end
        hs0 = bid_pop_hs + bid_upt_hs + ask_pop_hs + ask_upt_hs;
        r0  = rsp_hs;
        q0  = qry_cnt;
        @(negedge clk);
        lm_bid_rdy = 1'b1;
        lm_ask_rdy = 1'b1;
        rst = 1'b1;
        repeat (6) @(negedge clk);
        n_checks++;
        if ((bid_pop_hs + bid_upt_hs + ask_pop_hs + ask_upt_hs) != hs0 || rsp_hs != r0 ||
            qry_cnt != q0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL t5r_discard: got ops=%0d rsp=%0d qry=%0d busy=%b want 0/0/0/0",
                               bid_pop_hs + bid_upt_hs + ask_pop_hs + ask_upt_hs - hs0,
                               rsp_hs - r0, qry_cnt - q0, busy);
        end
    endtask

    // T6: three trades back to back with en held.
    task automatic test_back_to_back();
        int q0 = qry_cnt;
        bit ok;
        int cyc;
        trade_rsp_t exp_r;
        logic [15:0] qty;
        for (int i = 0; i < 3; i++) begin
            qty       = 16'(4 + i);
            dec_vld   = 1'b1;
            dec_trade = mk_trade(16'(16'h00b0 + i), 16'd90, qty, 16'(16'h00c0 + i), 16'd88, qty + 16'd3);
            exp_q.push_back('{bid_uid: 16'(16'h00b0 + i), ask_uid: 16'(16'h00c0 + i),
                              price: 16'd88, quantity: qty});
            en = 1'b1;
            wait_rsp(ok, cyc);
            if (i == 2) en = 1'b0;
            n_checks++;
            if (!ok || exp_q.size() == 0) begin
                n_fail++; $display("FAIL b2b_rsp%0d: rsp seen=%b queue=%0d", i, ok, exp_q.size());
            end else begin
                exp_r = exp_q.pop_front();
                if (rsp !== exp_r) begin
                    n_fail++; $display("FAIL b2b_rsp%0d: got %h want %h", i, rsp, exp_r);
                end
            end
        end
        wait_idle(ok);
        repeat (3) @(negedge clk);
        n_checks++;
        if (qry_cnt - q0 != 3 || busy !== 1'b0) begin
            n_fail++; $display("FAIL b2b_queries: got %0d busy=%b want 3/0", qry_cnt - q0, busy);
        end
`ifdef OB_CNTRL_LM_EXEC_STATS_EN
        n_checks++;
        if (stat_trades_r !== 32'd3 || stat_shares_r !== 32'd15) begin
            n_fail++; $display("FAIL stats: got trades=%0d shares=%0d want 3/15",
                               stat_trades_r, stat_shares_r);
        end
`endif
    endtask

    initial begin
        rst        = 1'b0;
        en         = 1'b0;
        lm_bid_rdy = 1'b1;
        lm_ask_rdy = 1'b1;
        rsp_accept = 1'b1;
        dec_vld    = 1'b0;
        dec_trade  = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_partial_fill();
        test_equal_fill();
        test_no_decision();
        test_bid_stall();
        test_accept_stall();
        test_reset_in_update();
        test_back_to_back();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: %0d responses missing", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
